// File: rtl/lsu_pkg.sv
// Shared types and defaults for the load/store unit controller.
package lsu_pkg;

  localparam int unsigned LSU_DATA_W = 32;
  localparam int unsigned LSU_DEPTH  = 16;
  // Wide enough to hold RD_LAT-1 for RD_LAT up to 4.
  localparam int unsigned LAT_CNT_W  = 3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } lsu_state_e;

endpackage

// File: rtl/lsu_lat_cnt.sv
// Load/decrement down-counter with zero flag, used to time the WAIT state.
module lsu_lat_cnt
  import lsu_pkg::*;
#(
  parameter int unsigned W = LAT_CNT_W
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic         zero
);

  logic [W-1:0] count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (dec && (count != '0)) begin
      count <= count - 1'b1;
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/lsu_ctrl.sv
// Load/store unit controller: one outstanding memory access, fixed read latency.
// Optional address bounds check enabled by defining LSU_BOUNDS_CHECK_EN.
module lsu_ctrl
  import lsu_pkg::*;
#(
  parameter int unsigned DATA_W = LSU_DATA_W,
  parameter int unsigned DEPTH  = LSU_DEPTH,
  parameter int unsigned RD_LAT = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [DATA_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              stall,
  output logic [DATA_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_mr,
  output logic              mem_mw,
  input  logic [DATA_W-1:0] mem_rdata
);

  if (RD_LAT < 1 || RD_LAT > 4 || DEPTH < 1) begin : g_cfg_check
    $error("lsu_ctrl: RD_LAT must be 1..4 and DEPTH nonzero");
  end

  lsu_state_e state_q, state_d;
  logic       we_q;
  logic       accept;
  logic       oob;
  logic       issue_go;
  logic       cnt_load;
  logic       cnt_dec;
  logic       cnt_zero;
  logic       capture;

  assign req_ready = (state_q == ST_IDLE) || (state_q == ST_RESP);
  assign accept    = req_valid && req_ready;
  assign stall     = req_valid && !req_ready;
  assign rsp_valid = (state_q == ST_RESP);

`ifdef LSU_BOUNDS_CHECK_EN
  logic err_q;

  assign oob     = (req_addr >= DATA_W'(DEPTH));
  assign rsp_err = rsp_valid && err_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q <= 1'b0;
    end else if (accept) begin
      err_q <= oob;
    end
  end
`else
  assign oob     = 1'b0;
  assign rsp_err = 1'b0;
`endif

  assign issue_go = accept && !oob;

  always_comb begin
    state_d  = state_q;
    cnt_load = 1'b0;
    cnt_dec  = 1'b0;
    capture  = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (accept) state_d = oob ? ST_RESP : ST_ISSUE;
      end
      ST_ISSUE: begin
        if (we_q) begin
          state_d = ST_RESP;
        end else begin
          state_d  = ST_WAIT;
          cnt_load = 1'b1;
        end
      end
      ST_WAIT: begin
        if (cnt_zero) begin
          state_d = ST_RESP;
          capture = 1'b1;
        end else begin
          cnt_dec = 1'b1;
        end
      end
      ST_RESP: begin
        if (accept) state_d = oob ? ST_RESP : ST_ISSUE;
        else        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Strobes are registered from the accept decision so they are high
  // exactly for the single ISSUE cycle that follows.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      we_q      <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_mr    <= 1'b0;
      mem_mw    <= 1'b0;
      rsp_rdata <= '0;
    end else begin
      state_q <= state_d;
      mem_mr  <= issue_go && !req_we;
      mem_mw  <= issue_go && req_we;
      if (issue_go) begin
        we_q      <= req_we;
        mem_addr  <= req_addr;
        mem_wdata <= req_wdata;
      end
      if (capture) begin
        rsp_rdata <= mem_rdata;
      end
    end
  end

  lsu_lat_cnt #(
    .W (LAT_CNT_W)
  ) u_lat_cnt (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (cnt_load),
    .load_val (LAT_CNT_W'(RD_LAT - 1)),
    .dec      (cnt_dec),
    .zero     (cnt_zero)
  );

endmodule

// File: tb/tb_lsu_ctrl.sv
// Directed self-checking bench for lsu_ctrl (RD_LAT=1, DEPTH=16, 32-bit).
module tb_lsu_ctrl;

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        stall;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_mr;
  logic        mem_mw;
  logic [31:0] mem_rdata;

  logic [31:0] mem [0:31];
  int unsigned n_chk;
  int unsigned n_bad;

  lsu_ctrl #(
    .DATA_W (32),
    .DEPTH  (16),
    .RD_LAT (1)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_we    (req_we),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err),
    .stall     (stall),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_mr    (mem_mr),
    .mem_mw    (mem_mw),
    .mem_rdata (mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single-port memory with one cycle of read latency.
  always @(posedge clk) begin
    if (mem_mw) mem[mem_addr[4:0]] <= mem_wdata;
    if (mem_mr) mem_rdata <= mem[mem_addr[4:0]];
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic we, input logic [31:0] a, input logic [31:0] d);
    req_valid = v;
    req_we    = we;
    req_addr  = a;
    req_wdata = d;
  endtask

  initial begin
    n_chk = 0;
    n_bad = 0;
    rst_n = 1'b0;
    mem_rdata = '0;
    drive(1'b0, 1'b0, 32'h0, 32'h0);
    repeat (2) @(posedge clk);
    #1;
    check("rst_mr", {31'b0, mem_mr}, 32'd0);
    check("rst_mw", {31'b0, mem_mw}, 32'd0);
    check("rst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
    check("rst_rsp_err", {31'b0, rsp_err}, 32'd0);
    check("rst_rdata", rsp_rdata, 32'd0);
    check("rst_addr", mem_addr, 32'd0);
    check("rst_wdata", mem_wdata, 32'd0);

    // Store(3, DEADBEEF) offered in the first cycle after reset release
    @(negedge clk);
    rst_n = 1'b1;
    drive(1'b1, 1'b1, 32'd3, 32'hDEADBEEF);
    check("st_ready_first", {31'b0, req_ready}, 32'd1);
    step();
    drive(1'b0, 1'b0, 32'd0, 32'd0);
    check("st_issue_mw", {31'b0, mem_mw}, 32'd1);
    check("st_issue_mr", {31'b0, mem_mr}, 32'd0);
    check("st_issue_addr", mem_addr, 32'd3);
    check("st_issue_wdata", mem_wdata, 32'hDEADBEEF);
    check("st_issue_ready", {31'b0, req_ready}, 32'd0);
    check("st_issue_valid", {31'b0, rsp_valid}, 32'd0);
    step();
    check("st_resp_valid", {31'b0, rsp_valid}, 32'd1);
    check("st_resp_mw", {31'b0, mem_mw}, 32'd0);
    check("st_resp_err", {31'b0, rsp_err}, 32'd0);
    check("st_resp_rdata", rsp_rdata, 32'd0);
    step();
    check("st_idle_valid", {31'b0, rsp_valid}, 32'd0);

    // Load(3) -> DEADBEEF at acceptance + 3
    drive(1'b1, 1'b0, 32'd3, 32'd0);
    step();
    drive(1'b0, 1'b0, 32'd0, 32'd0);
    check("ld_issue_mr", {31'b0, mem_mr}, 32'd1);
    check("ld_issue_mw", {31'b0, mem_mw}, 32'd0);
    check("ld_issue_addr", mem_addr, 32'd3);
    step();
    check("ld_wait_mr", {31'b0, mem_mr}, 32'd0);
    check("ld_wait_valid", {31'b0, rsp_valid}, 32'd0);
    step();
    check("ld_resp_valid", {31'b0, rsp_valid}, 32'd1);
    check("ld_resp_rdata", rsp_rdata, 32'hDEADBEEF);
    step();
    check("ld_idle_valid", {31'b0, rsp_valid}, 32'd0);

    // Back-to-back: store(5,0x11), load(5), load(3) with req_valid held
    drive(1'b1, 1'b1, 32'd5, 32'h11);
    step();
    drive(1'b1, 1'b0, 32'd5, 32'd0);
    check("b2b_issue_stall", {31'b0, stall}, 32'd1);
    check("b2b_issue_mw", {31'b0, mem_mw}, 32'd1);
    check("b2b_issue_addr", mem_addr, 32'd5);
    step();
    check("b2b_resp1_valid", {31'b0, rsp_valid}, 32'd1);
    check("b2b_resp1_ready", {31'b0, req_ready}, 32'd1);
    check("b2b_resp1_stall", {31'b0, stall}, 32'd0);
    step();
    drive(1'b1, 1'b0, 32'd3, 32'd0);
    check("b2b_ld_issue_mr", {31'b0, mem_mr}, 32'd1);
    check("b2b_ld_issue_addr", mem_addr, 32'd5);
    check("b2b_ld_issue_stall", {31'b0, stall}, 32'd1);
    step();
    check("b2b_ld_wait_stall", {31'b0, stall}, 32'd1);
    check("b2b_ld_wait_addr", mem_addr, 32'd5);
    check("b2b_ld_wait_valid", {31'b0, rsp_valid}, 32'd0);
    step();
    check("b2b_ld_resp_valid", {31'b0, rsp_valid}, 32'd1);
    check("b2b_ld_resp_rdata", rsp_rdata, 32'h11);
    step();
    drive(1'b0, 1'b0, 32'd0, 32'd0);
    check("b2b_ld3_issue_mr", {31'b0, mem_mr}, 32'd1);
    check("b2b_ld3_issue_addr", mem_addr, 32'd3);
    check("b2b_ld3_hold_rdata", rsp_rdata, 32'h11);
    step();
    step();
    check("b2b_ld3_resp_valid", {31'b0, rsp_valid}, 32'd1);
    check("b2b_ld3_resp_rdata", rsp_rdata, 32'hDEADBEEF);
    step();

    // Reset during WAIT of load(7)
    drive(1'b1, 1'b0, 32'd7, 32'd0);
    step();
    drive(1'b0, 1'b0, 32'd0, 32'd0);
    step();
    check("rw_wait_ready", {31'b0, req_ready}, 32'd0);
    #2;
    rst_n = 1'b0;
    #1;
    check("rw_rst_valid", {31'b0, rsp_valid}, 32'd0);
    check("rw_rst_rdata", rsp_rdata, 32'd0);
    check("rw_rst_addr", mem_addr, 32'd0);
    check("rw_rst_wdata", mem_wdata, 32'd0);
    check("rw_rst_ready", {31'b0, req_ready}, 32'd1);
    @(negedge clk);
    check("rw_rst_valid2", {31'b0, rsp_valid}, 32'd0);
    rst_n = 1'b1;
    drive(1'b1, 1'b1, 32'd2, 32'h55);
    check("rw_post_ready", {31'b0, req_ready}, 32'd1);
    step();
    drive(1'b0, 1'b0, 32'd0, 32'd0);
    check("rw_post_mw", {31'b0, mem_mw}, 32'd1);
    check("rw_post_addr", mem_addr, 32'd2);
    check("rw_post_wdata", mem_wdata, 32'h55);
    step();
    check("rw_post_valid", {31'b0, rsp_valid}, 32'd1);
    check("rw_post_rdata", rsp_rdata, 32'd0);
    step();

    // Out-of-range load(16)
    drive(1'b1, 1'b0, 32'd16, 32'd0);
    step();
    drive(1'b0, 1'b0, 32'd0, 32'd0);
`ifdef LSU_BOUNDS_CHECK_EN
    check("oob_mr", {31'b0, mem_mr}, 32'd0);
    check("oob_valid", {31'b0, rsp_valid}, 32'd1);
    check("oob_err", {31'b0, rsp_err}, 32'd1);
    check("oob_rdata", rsp_rdata, 32'd0);
    step();
    check("oob_idle_valid", {31'b0, rsp_valid}, 32'd0);
`else
    check("oob_mr", {31'b0, mem_mr}, 32'd1);
    check("oob_addr", mem_addr, 32'd16);
    check("oob_valid_early", {31'b0, rsp_valid}, 32'd0);
    step();
    step();
    check("oob_valid", {31'b0, rsp_valid}, 32'd1);
    check("oob_err", {31'b0, rsp_err}, 32'd0);
`endif
    step();

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
